// File: rtl/miriscv_apb_bridge.sv
// APB master bridge for the miriscv data port: one outstanding request, SETUP/ACCESS with waits.
// Optional ACCESS timeout is enabled by defining MIRISCV_APB_BRIDGE_TIMEOUT_EN.
module miriscv_apb_bridge #(
    parameter int unsigned NUM_SLAVES     = 2,
    parameter int unsigned SEL_LSB        = 12,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                     clk_i,
    input  logic                     arstn_i,
    input  logic                     data_req_i,
    input  logic                     data_we_i,
    input  logic [3:0]               data_be_i,
    input  logic [31:0]              data_addr_i,
    input  logic [31:0]              data_wdata_i,
    output logic                     data_rvalid_o,
    output logic [31:0]              data_rdata_o,
    output logic                     data_err_o,
    output logic [NUM_SLAVES-1:0]    psel_o,
    output logic                     penable_o,
    output logic                     pwrite_o,
    output logic [31:0]              paddr_o,
    output logic [31:0]              pwdata_o,
    output logic [3:0]               pstrb_o,
    input  logic [NUM_SLAVES*32-1:0] prdata_i,
    input  logic [NUM_SLAVES-1:0]    pready_i,
    input  logic [NUM_SLAVES-1:0]    pslverr_i
);

    localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    rvalid_q, rvalid_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    pwrite_q, pwrite_d;
    logic [31:0]             paddr_q, paddr_d;
    logic [31:0]             pwdata_q, pwdata_d;
    logic [3:0]              pstrb_q, pstrb_d;

    logic [SW-1:0]           req_idx;
    logic                    req_idx_ok;
    logic                    pready_sel;
    logic                    pslverr_sel;
    logic [31:0]             prdata_sel;
    logic                    unused_cfg;

    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign req_idx    = data_addr_i[SEL_LSB +: SW];

    // A power-of-two slave count makes every index field value legal.
    if (NUM_SLAVES == (1 << SW)) begin : g_idx_full
        assign req_idx_ok = 1'b1;
    end else begin : g_idx_part
        assign req_idx_ok = (32'(req_idx) < NUM_SLAVES);
    end

`ifdef MIRISCV_APB_BRIDGE_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    // The registered one-hot select steers the slave response mux.
    always_comb begin
        prdata_sel  = '0;
        pready_sel  = |(pready_i & psel_q);
        pslverr_sel = |(pslverr_i & psel_q);
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (psel_q[k]) begin
                prdata_sel = prdata_sel | prdata_i[k*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
`ifdef MIRISCV_APB_BRIDGE_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (data_req_i) begin
                    paddr_d  = data_addr_i;
                    pwrite_d = data_we_i;
                    pwdata_d = data_wdata_i;
                    pstrb_d  = data_we_i ? data_be_i : 4'b0000;
                    if (req_idx_ok) begin
                        state_d = StSetup;
                        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
                            psel_d[k] = (32'(req_idx) == k);
                        end
`ifdef MIRISCV_APB_BRIDGE_TIMEOUT_EN
                        cnt_d = '0;
`endif
                    end else begin
                        state_d  = StResp;
                        rvalid_d = 1'b1;
                        rdata_d  = '0;
                        err_d    = 1'b1;
                    end
                end
            end
            StSetup: begin
                state_d   = StAccess;
                penable_d = 1'b1;
            end
            StAccess: begin
                if (pready_sel) begin
                    state_d   = StResp;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = pwrite_q ? 32'h0 : prdata_sel;
                    err_d     = pslverr_sel;
                end
`ifdef MIRISCV_APB_BRIDGE_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = StResp;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = '0;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d   = StIdle;
                psel_d    = '0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q   <= StIdle;
            psel_q    <= '0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
`ifdef MIRISCV_APB_BRIDGE_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
`ifdef MIRISCV_APB_BRIDGE_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;

endmodule

// File: doc/miriscv_apb_bridge.md
# miriscv_apb_bridge

APB master bridge between the miriscv core data port and the SoC's APB peripherals (UART, timer). It accepts a single outstanding core data request and runs a proper two-phase APB setup/access transfer to the selected slave. It honours `PREADY` wait states and returns the read data with `data_rvalid_o`, replacing the single-cycle psel/penable shortcut. The SoC steers only peripheral-region requests (addr[31]=1) to this block; RAM traffic bypasses it.

## Interface
- `NUM_SLAVES`, 2: number of APB slaves; one `psel` bit per slave.
- `SEL_LSB`, 12: LSB of the slave-index field in the request address. Field width is `SW = max(1, $clog2(NUM_SLAVES))`.
- `TIMEOUT_CYCLES`, 256: maximum number of ACCESS cycles without `PREADY`; only used with the timeout macro.
- `clk_i` in 1: single clock, rising edge.
- `arstn_i` in 1: reset; one clock; reset is synchronous and active-low.
- `data_req_i` in 1: core request, held stable by the core until `data_rvalid_o`.
- `data_we_i` in 1: 1 = write.
- `data_be_i` in 4: byte enables.
- `data_addr_i` in 32: byte address.
- `data_wdata_i` in 32: write data.
- `data_rvalid_o` out 1: one-cycle response strobe.
- `data_rdata_o` out 32: read data, valid with `data_rvalid_o`.
- `data_err_o` out 1: error flag, valid with `data_rvalid_o`.
- `psel_o` out NUM_SLAVES: one-hot slave select.
- `penable_o` out 1: APB access phase.
- `pwrite_o` out 1: APB write.
- `paddr_o` out 32: APB address.
- `pwdata_o` out 32: APB write data.
- `pstrb_o` out 4: APB write strobes.
- `prdata_i` in NUM_SLAVES*32: slave read data; slave k occupies bits [k*32 +: 32].
- `pready_i` in NUM_SLAVES: per-slave ready.
- `pslverr_i` in NUM_SLAVES: per-slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - If `data_req_i`=1: latch addr, we, be and wdata. Compute `idx = addr[SEL_LSB +: SW]`.
  - If `idx < NUM_SLAVES`: go to SETUP.
  - Otherwise: go to RESP with err=1 and rdata=0. No `psel` is asserted.
- **SETUP**: `psel_o[idx]`=1, `penable_o`=0. Always go to ACCESS.
- **ACCESS**
  - `psel_o[idx]`=1, `penable_o`=1.
  - On `pready_i[idx]`=1: register `prdata_i[idx]` (0 on writes) and `pslverr_i[idx]`, then go to RESP.
  - Otherwise stay in ACCESS.
- **RESP**: `data_rvalid_o`=1 for exactly one cycle with the registered rdata/err, then go to IDLE. `data_req_i` is ignored in RESP.
- APB outputs during a transfer:
  - `paddr_o`, `pwrite_o` and `pwdata_o` are driven from the latched values and stay stable through SETUP and ACCESS.
  - `pstrb_o` = latched be on writes, 4'b0000 on reads.
- Read data and the other slaves:
  - `data_rdata_o` is 0 on write responses.
  - Unselected slaves' `pready`, `pslverr` and `prdata` are ignored.

## Timing
- Reset values: state IDLE; `psel_o`=0, `penable_o`=0, `data_rvalid_o`=0, `data_err_o`=0. `data_rdata_o`, `paddr_o`, `pwdata_o`, `pstrb_o` and `pwrite_o` all reset to 0.
- All outputs are registered or decoded from state; there is no combinational path from `data_req_i` to the APB outputs.
- Latency: request sampled at edge 0 → SETUP in cycle 1 → ACCESS in cycle 2 → `data_rvalid_o` in cycle 3 when `pready` is 1 at the first ACCESS. Each wait state adds 1 cycle.
- Out-of-range index: `data_rvalid_o` appears in cycle 1.
- Back-to-back transfers: the core may present the next request in the cycle after `data_rvalid_o`. IDLE samples it, so the minimum issue interval is 4 cycles.
- Reset mid-transfer: at the next edge with `arstn_i`=0, `psel_o` and `penable_o` drop to 0, the FSM returns to IDLE, and no response is issued.

## Configuration
- `MIRISCV_APB_BRIDGE_TIMEOUT_EN` defined:
  - An ACCESS-cycle counter clears on entry to SETUP and increments in each ACCESS cycle without `pready`.
  - When it reaches `TIMEOUT_CYCLES` without `pready`: drop `psel_o`/`penable_o`, go to RESP with err=1 and rdata=0.
- Macro undefined: no counter is built; ACCESS waits on `pready` indefinitely.

## Test plan
- Read, slave 0 (addr 0x8000_0004), pready=1 immediately, prdata=0x1234_5678 → SETUP at cycle 1, ACCESS at cycle 2, rvalid at cycle 3 with rdata 0x1234_5678 and err=0.
- Write to slave 1 (addr 0x8000_1008, be 4'b0011, wdata 0xAABB_CCDD), 3 wait states → `psel_o`=2'b10, `pstrb_o`=4'b0011, paddr/pwdata stable throughout, rvalid at cycle 6 with rdata=0.
- Read with `pslverr_i[0]`=1 at pready → rvalid with err=1.
- Back-to-back: two reads issued one cycle after each rvalid → `psel` rises for each, with no overlap and no lost request.
- Reset asserted during ACCESS → `psel`/`penable` are 0 at the next edge and no rvalid follows. With `MIRISCV_APB_BRIDGE_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, pready held at 0 → err=1 response 8 ACCESS cycles after entering ACCESS.
